riscv_multicycle_ctrl: RTL and testbench
========================================

Name: riscv_multicycle_ctrl

Overview:
- Main control FSM for the multicycle RV32I core variant. The datapath shares one memory port between fetch and load/store and holds state in IR/OldPC/ALUOut registers.
- Sequences that datapath one micro-step per cycle, supporting lw, sw, R-type, I-type ALU, beq and jal.
- Memory accesses use a req/ready handshake guarded by a wait-cycle watchdog.
- Illegal opcodes and memory timeouts send the FSM to a sticky trap state.

Parameters:
- MEM_TIMEOUT, 16: maximum number of cycles a memory state waits for mem_ready before trapping (legal range 1..255).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- opcode  input  7  IR[6:0] of the latched instruction.
- Zero  input  1  ALU zero flag.
- mem_ready  input  1  memory completes the current access this cycle.
- mem_req  output  1  memory access request.
- MemWrite  output  1  store strobe; valid only together with mem_req.
- AdrSrc  output  1  memory address select: 0 = PC, 1 = ALUOut.
- IRWrite  output  1  latch instruction and OldPC.
- PCWrite  output  1  PC register enable.
- RegWrite  output  1  register file write enable.
- ResultSrc  output  2  result select: 00 = ALUOut, 01 = read data, 10 = ALUResult.
- ALUSrcA  output  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1 data.
- ALUSrcB  output  2  ALU B select: 00 = rs2 data, 01 = ImmExt, 10 = constant 4.
- ALUOp  output  2  ALU operation: 00 = add, 01 = sub/compare, 10 = decode funct fields.
- retire  output  1  one-cycle pulse when an instruction completes.
- trap  output  1  sticky; high while in TRAP.
- trap_cause  output  2  01 = illegal opcode, 10 = memory timeout, 00 = none.

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, TRAP.
- Reset:
  - While reset=0: state=FETCH, wait counter=0, trap_cause=00.
  - While reset=0, every output is forced to 0, including mem_req.
  - The first request is issued on the first cycle after reset deasserts.
- Moore outputs; any control not listed for a state is 0.
- FETCH:
  - mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite and PCWrite are asserted only in the cycle where mem_ready=1, so PC advances by exactly 4 per fetch.
  - Transition to DECODE on mem_ready=1.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (computes the branch/jump target). Next state by opcode:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BEQ
  - 1101111 → JAL
  - any other value → TRAP with cause 01
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next state is MEMREAD if opcode[5]=0, otherwise MEMWRITE.
- MEMREAD:
  - mem_req=1, AdrSrc=1.
  - Transition to MEMWB on mem_ready.
- MEMWB: ResultSrc=01, RegWrite=1, retire=1. Next state FETCH.
- MEMWRITE:
  - mem_req=1, MemWrite=1, AdrSrc=1.
  - On mem_ready: retire=1 that cycle, next state FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next state ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next state ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, retire=1. Next state FETCH.
- BEQ:
  - ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00.
  - PCWrite=Zero (loads the ALUOut target), retire=1.
  - Next state FETCH.
- JAL:
  - ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1.
  - Next state ALUWB: rd receives OldPC+4 and retire fires in ALUWB.
- Handshake:
  - mem_req stays high and address/control stay stable until mem_ready is sampled high.
  - mem_ready is ignored in non-memory states.
  - The FSM never drops mem_req without mem_ready, except on timeout or reset.
- Watchdog:
  - An 8-bit counter clears on entry to any memory state (FETCH, MEMREAD, MEMWRITE).
  - It increments each cycle that mem_req=1 and mem_ready=0.
  - When it equals MEM_TIMEOUT while mem_ready=0, the FSM goes to TRAP with cause 10.
  - If mem_ready=1 arrives in the same cycle the count reaches MEM_TIMEOUT, ready wins and no trap occurs.
- TRAP:
  - All controls are 0; trap=1; trap_cause is held.
  - Only reset exits TRAP.
- Reset asserted mid-access: mem_req drops asynchronously, and no PC or register write occurs.

Decomposition:
- Shared package riscv_pkg holds:
  - ctrl_state_enum (the 12 states)
  - opcode constants OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH, OP_JAL
  - ALUOp encodings ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT
  - trap cause constants
- One sub-module, mc_outdec: a combinational decoder from (state, mem_ready, Zero) to the control word. The top module keeps the state register, next-state logic and watchdog.

Test Plan:
- Reset release with mem_ready tied to 1 and opcode=0110011:
  - Sequence is FETCH→DECODE→EXECR→ALUWB→FETCH.
  - Exactly one retire pulse per 4 cycles; PCWrite is high only in the FETCH cycles.
- lw (0000011) with mem_ready delayed 3 cycles in MEMREAD:
  - mem_req and AdrSrc=1 are held for 4 cycles.
  - RegWrite is asserted in MEMWB with ResultSrc=01; 5 states excluding waits.
- beq (1100011):
  - Zero=1 gives PCWrite=1 in the BEQ state.
  - Zero=0 gives PCWrite=0 in the BEQ state.
  - retire=1 in both cases.
- jal (1101111): the JAL state asserts PCWrite=1 with ALUSrcA=01 and ALUSrcB=10, then ALUWB asserts RegWrite=1.
- Illegal opcode 1110011: after DECODE, trap=1 and trap_cause=01. Everything stays idle for 20 cycles, then reset returns the FSM to FETCH with trap=0.
- Watchdog with MEM_TIMEOUT=4:
  - mem_ready held at 0 in FETCH traps with trap_cause=10 on the 4th wait cycle.
  - A repeat run with mem_ready=1 on exactly the 4th wait cycle proceeds to DECODE with no trap.

Source files
------------

// File: rtl/riscv_pkg.sv
// ============================================================================
// riscv_pkg : shared types and encodings for the multicycle RV32I control
// Revision  : 1.0
// ============================================================================
`default_nettype none

package riscv_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } ctrl_state_enum;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] TRAP_NONE    = 2'b00;
  localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
  localparam logic [1:0] TRAP_TIMEOUT = 2'b10;

  function automatic logic is_mem_state(input ctrl_state_enum s);
    return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mc_outdec.sv
// ============================================================================
// mc_outdec : Moore control-word decoder for the multicycle controller
// Revision  : 1.0
// ============================================================================
`default_nettype none

module mc_outdec
  import riscv_pkg::*;
(
  input  logic [3:0] state_i,
  input  logic       mem_ready_i,
  input  logic       zero_i,
  output logic       mem_req_o,
  output logic       mem_write_o,
  output logic       adr_src_o,
  output logic       ir_write_o,
  output logic       pc_write_o,
  output logic       reg_write_o,
  output logic [1:0] result_src_o,
  output logic [1:0] alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_o,
  output logic       retire_o,
  output logic       trap_o
);

  always_comb begin
    mem_req_o    = 1'b0;
    mem_write_o  = 1'b0;
    adr_src_o    = 1'b0;
    ir_write_o   = 1'b0;
    pc_write_o   = 1'b0;
    reg_write_o  = 1'b0;
    result_src_o = 2'b00;
    alu_src_a_o  = 2'b00;
    alu_src_b_o  = 2'b00;
    alu_op_o     = ALUOP_ADD;
    retire_o     = 1'b0;
    trap_o       = 1'b0;
    case (ctrl_state_enum'(state_i))
      S_FETCH: begin
        // PC+4 is written back only on the completing cycle of the fetch
        mem_req_o    = 1'b1;
        alu_src_b_o  = 2'b10;
        result_src_o = 2'b10;
        ir_write_o   = mem_ready_i;
        pc_write_o   = mem_ready_i;
      end
      S_DECODE: begin
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b01;
      end
      S_MEMREAD: begin
        mem_req_o = 1'b1;
        adr_src_o = 1'b1;
      end
      S_MEMWB: begin
        result_src_o = 2'b01;
        reg_write_o  = 1'b1;
        retire_o     = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req_o   = 1'b1;
        mem_write_o = 1'b1;
        adr_src_o   = 1'b1;
        retire_o    = mem_ready_i;
      end
      S_EXECR: begin
        alu_src_a_o = 2'b10;
        alu_op_o    = ALUOP_FUNCT;
      end
      S_EXECI: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b01;
        alu_op_o    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        reg_write_o = 1'b1;
        retire_o    = 1'b1;
      end
      S_BEQ: begin
        alu_src_a_o = 2'b10;
        alu_op_o    = ALUOP_SUB;
        pc_write_o  = zero_i;
        retire_o    = 1'b1;
      end
      S_JAL: begin
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b10;
        pc_write_o  = 1'b1;
      end
      S_TRAP: begin
        trap_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/riscv_multicycle_ctrl.sv
// ============================================================================
// riscv_multicycle_ctrl : main control FSM with memory watchdog and trap
// Revision              : 1.0
// ============================================================================
`default_nettype none

module riscv_multicycle_ctrl
  import riscv_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       retire,
  output logic       trap,
  output logic [1:0] trap_cause
);

  ctrl_state_enum state_q, state_d;
  logic [7:0]     wcnt_q, wcnt_d;
  logic [1:0]     cause_q, cause_d;
  logic           timeout;

  // The wait that would bring the count to MEM_TIMEOUT is the last one allowed
  assign timeout = (wcnt_q == 8'(MEM_TIMEOUT - 1)) && !mem_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      wcnt_q  <= 8'd0;
      cause_q <= TRAP_NONE;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (timeout) begin
          state_d = S_TRAP;
          cause_d = TRAP_TIMEOUT;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXECR;
          OP_I:              state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BEQ;
          OP_JAL:            state_d = S_JAL;
          default: begin
            state_d = S_TRAP;
            cause_d = TRAP_ILLEGAL;
          end
        endcase
      end
      S_MEMADR:  state_d = opcode[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: begin
        if (mem_ready) begin
          state_d = S_MEMWB;
        end else if (timeout) begin
          state_d = S_TRAP;
          cause_d = TRAP_TIMEOUT;
        end
      end
      S_MEMWRITE: begin
        if (mem_ready) begin
          state_d = S_FETCH;
        end else if (timeout) begin
          state_d = S_TRAP;
          cause_d = TRAP_TIMEOUT;
        end
      end
      S_MEMWB, S_ALUWB, S_BEQ: state_d = S_FETCH;
      S_EXECR, S_EXECI, S_JAL: state_d = S_ALUWB;
      S_TRAP:                  state_d = S_TRAP;
      default:                 state_d = S_TRAP;
    endcase
  end

  // Any state change is an entry into a fresh state, so the wait count restarts
  always_comb begin
    wcnt_d = wcnt_q;
    if (state_d != state_q) begin
      wcnt_d = 8'd0;
    end else if (is_mem_state(state_q) && !mem_ready) begin
      wcnt_d = wcnt_q + 8'd1;
    end
  end

  logic       dec_mem_req, dec_mem_write, dec_adr_src, dec_ir_write;
  logic       dec_pc_write, dec_reg_write, dec_retire, dec_trap;
  logic [1:0] dec_result_src, dec_alu_src_a, dec_alu_src_b, dec_alu_op;

  mc_outdec u_outdec (
    .state_i      (state_q),
    .mem_ready_i  (mem_ready),
    .zero_i       (Zero),
    .mem_req_o    (dec_mem_req),
    .mem_write_o  (dec_mem_write),
    .adr_src_o    (dec_adr_src),
    .ir_write_o   (dec_ir_write),
    .pc_write_o   (dec_pc_write),
    .reg_write_o  (dec_reg_write),
    .result_src_o (dec_result_src),
    .alu_src_a_o  (dec_alu_src_a),
    .alu_src_b_o  (dec_alu_src_b),
    .alu_op_o     (dec_alu_op),
    .retire_o     (dec_retire),
    .trap_o       (dec_trap)
  );

  // Gating with reset makes every control, mem_req included, drop asynchronously
  assign mem_req    = reset & dec_mem_req;
  assign MemWrite   = reset & dec_mem_write;
  assign AdrSrc     = reset & dec_adr_src;
  assign IRWrite    = reset & dec_ir_write;
  assign PCWrite    = reset & dec_pc_write;
  assign RegWrite   = reset & dec_reg_write;
  assign ResultSrc  = {2{reset}} & dec_result_src;
  assign ALUSrcA    = {2{reset}} & dec_alu_src_a;
  assign ALUSrcB    = {2{reset}} & dec_alu_src_b;
  assign ALUOp      = {2{reset}} & dec_alu_op;
  assign retire     = reset & dec_retire;
  assign trap       = reset & dec_trap;
  assign trap_cause = {2{reset}} & cause_q;

endmodule

`default_nettype wire

// File: tb/tb_riscv_multicycle_ctrl.sv
// ============================================================================
// tb_riscv_multicycle_ctrl : directed self-checking bench for the controller
// Revision                 : 1.0
// ============================================================================
`default_nettype none

module tb_riscv_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic       Zero;
  logic       mem_ready;
  logic       mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, retire, trap;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, trap_cause;

  int n_checks = 0;
  int n_errors = 0;
  int retires  = 0;

  always #5 clk = ~clk;

  riscv_multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .Zero       (Zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .MemWrite   (MemWrite),
    .AdrSrc     (AdrSrc),
    .IRWrite    (IRWrite),
    .PCWrite    (PCWrite),
    .RegWrite   (RegWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUOp      (ALUOp),
    .retire     (retire),
    .trap       (trap),
    .trap_cause (trap_cause)
  );

  // Control word: {mem_req,MemWrite,AdrSrc,IRWrite,PCWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUOp,retire,trap,trap_cause}
  logic [17:0] ctrl_w;
  assign ctrl_w = {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
                   ResultSrc, ALUSrcA, ALUSrcB, ALUOp, retire, trap, trap_cause};

  function automatic logic [17:0] cw(input logic mr, input logic mw, input logic as,
                                     input logic irw, input logic pcw, input logic rw,
                                     input logic [1:0] rs, input logic [1:0] sa,
                                     input logic [1:0] sb, input logic [1:0] op,
                                     input logic ret, input logic tr, input logic [1:0] tc);
    return {mr, mw, as, irw, pcw, rw, rs, sa, sb, op, ret, tr, tc};
  endfunction

  localparam logic [17:0] W_IDLE    = 18'd0;
  localparam logic [17:0] W_FWAIT   = cw(1,0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,0,0,2'b00);
  localparam logic [17:0] W_FRDY    = cw(1,0,0,1,1,0,2'b10,2'b00,2'b10,2'b00,0,0,2'b00);
  localparam logic [17:0] W_DECODE  = cw(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,0,0,2'b00);
  localparam logic [17:0] W_MEMADR  = cw(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,0,0,2'b00);
  localparam logic [17:0] W_MEMRD   = cw(1,0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,0,0,2'b00);
  localparam logic [17:0] W_MEMWB   = cw(0,0,0,0,0,1,2'b01,2'b00,2'b00,2'b00,1,0,2'b00);
  localparam logic [17:0] W_MWWAIT  = cw(1,1,1,0,0,0,2'b00,2'b00,2'b00,2'b00,0,0,2'b00);
  localparam logic [17:0] W_MWRDY   = cw(1,1,1,0,0,0,2'b00,2'b00,2'b00,2'b00,1,0,2'b00);
  localparam logic [17:0] W_EXECR   = cw(0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,0,0,2'b00);
  localparam logic [17:0] W_EXECI   = cw(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b10,0,0,2'b00);
  localparam logic [17:0] W_ALUWB   = cw(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,1,0,2'b00);
  localparam logic [17:0] W_BEQ_Z1  = cw(0,0,0,0,1,0,2'b00,2'b10,2'b00,2'b01,1,0,2'b00);
  localparam logic [17:0] W_BEQ_Z0  = cw(0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b01,1,0,2'b00);
  localparam logic [17:0] W_JAL     = cw(0,0,0,0,1,0,2'b00,2'b01,2'b10,2'b00,0,0,2'b00);
  localparam logic [17:0] W_TRAP_IL = cw(0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,0,1,2'b01);
  localparam logic [17:0] W_TRAP_TO = cw(0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,0,1,2'b10);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Check the current control word, then advance to 2 time units past the next edge
  task automatic step(input string tag, input logic [17:0] exp);
    #1;
    check(tag, 32'(ctrl_w), 32'(exp));
    if (retire === 1'b1) retires++;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    check("reset_idle", 32'(ctrl_w), 32'(W_IDLE));
    @(posedge clk);
    #2;
    reset = 1'b1;
  endtask

  initial begin
    reset     = 1'b0;
    opcode    = 7'b0110011;
    Zero      = 1'b0;
    mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    do_reset();

    // R-type back to back with ready tied high
    retires = 0;
    for (int k = 0; k < 2; k++) begin
      step("r_fetch", W_FRDY);
      step("r_decode", W_DECODE);
      step("r_execr", W_EXECR);
      step("r_aluwb", W_ALUWB);
    end
    check("r_retire_count", 32'(retires), 32'd2);

    // lw with three wait cycles in MEMREAD
    opcode = 7'b0000011;
    step("lw_fetch", W_FRDY);
    step("lw_decode", W_DECODE);
    step("lw_memadr", W_MEMADR);
    mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) step("lw_memrd_wait", W_MEMRD);
    mem_ready = 1'b1;
    step("lw_memrd_rdy", W_MEMRD);
    step("lw_memwb", W_MEMWB);

    // sw with one wait cycle
    opcode = 7'b0100011;
    step("sw_fetch", W_FRDY);
    step("sw_decode", W_DECODE);
    step("sw_memadr", W_MEMADR);
    mem_ready = 1'b0;
    step("sw_wait", W_MWWAIT);
    mem_ready = 1'b1;
    step("sw_rdy", W_MWRDY);

    // I-type; mem_ready low in non-memory states has no effect
    opcode = 7'b0010011;
    step("i_fetch", W_FRDY);
    mem_ready = 1'b0;
    step("i_decode", W_DECODE);
    step("i_execi", W_EXECI);
    step("i_aluwb", W_ALUWB);
    mem_ready = 1'b1;

    // beq taken and not taken
    opcode = 7'b1100011;
    Zero   = 1'b1;
    step("beq1_fetch", W_FRDY);
    step("beq1_decode", W_DECODE);
    step("beq_taken", W_BEQ_Z1);
    Zero = 1'b0;
    step("beq0_fetch", W_FRDY);
    step("beq0_decode", W_DECODE);
    step("beq_not_taken", W_BEQ_Z0);

    // jal
    opcode = 7'b1101111;
    step("jal_fetch", W_FRDY);
    step("jal_decode", W_DECODE);
    step("jal_jal", W_JAL);
    step("jal_aluwb", W_ALUWB);

    // Illegal opcode then 20 idle trap cycles with toggling inputs
    opcode = 7'b1110011;
    step("ill_fetch", W_FRDY);
    step("ill_decode", W_DECODE);
    for (int k = 0; k < 20; k++) begin
      mem_ready = k[0];
      Zero      = k[1];
      step("ill_trap", W_TRAP_IL);
    end
    mem_ready = 1'b1;
    Zero      = 1'b0;
    opcode    = 7'b0110011;
    do_reset();
    step("ill_after_reset", W_FRDY);
    step("ill_after_decode", W_DECODE);
    step("ill_after_execr", W_EXECR);
    step("ill_after_aluwb", W_ALUWB);

    // Watchdog expiry in FETCH on the 4th wait cycle
    mem_ready = 1'b0;
    for (int k = 0; k < 4; k++) step("wd_fetch_wait", W_FWAIT);
    for (int k = 0; k < 3; k++) begin
      mem_ready = k[0];
      step("wd_trap", W_TRAP_TO);
    end
    mem_ready = 1'b0;
    do_reset();

    // Ready on the 4th cycle wins over the watchdog
    for (int k = 0; k < 3; k++) step("wd2_fetch_wait", W_FWAIT);
    mem_ready = 1'b1;
    step("wd2_fetch_rdy", W_FRDY);
    step("wd2_decode", W_DECODE);
    step("wd2_execr", W_EXECR);
    step("wd2_aluwb", W_ALUWB);

    // Reset asserted in the middle of a load access
    opcode = 7'b0000011;
    step("mid_fetch", W_FRDY);
    step("mid_decode", W_DECODE);
    step("mid_memadr", W_MEMADR);
    mem_ready = 1'b0;
    step("mid_memrd", W_MEMRD);
    do_reset();
    mem_ready = 1'b1;
    opcode    = 7'b0110011;
    step("mid_after_reset", W_FRDY);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL sim_timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
